axi_rchn_router: RTL and testbench
==================================

Name: axi_rchn_router

Overview:
- Read-data (R) return path of the AXI interconnect: routes R beats from the single downstream slave back to the upstream master that won the corresponding AR arbitration.
- Holds an internal FIFO of one-hot granted-master IDs, pushed on each downstream AR handshake and popped on the last R beat of each burst.
- Uses a 2-entry skid buffer on the R path, so every output toward the upstream masters is registered.
- Sits beside the AR arbiter, mirroring the W/B routing used on the write side.

Parameters:
- master_n, 4, number of upstream masters; legal range [2, 8].
- grant_fifo_depth, 4, maximum outstanding read bursts (grant-ID FIFO entries); power of 2, range [2, 16].
- simulation_delay, 1, delay on register updates for simulation only.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ar_grant_valid  in  1  AR handshake to downstream this cycle; push the grant ID
- ar_grant_onehot  in  master_n  one-hot ID of the granted master
- ar_grant_ready  out  1  grant FIFO not full; AR arbiter must not complete an AR while this is low
- m_r_payload  in  34  downstream R {rresp[1:0], rdata[31:0]}
- m_r_last  in  1  downstream R last
- m_r_valid  in  1  downstream R valid
- m_r_ready  out  1  downstream R ready
- s_r_payload  out  34  R payload, broadcast to all upstream masters
- s_r_last  out  1  R last, broadcast
- s_r_valid  out  8  per-master R valid; bits [7:master_n] tied to 0
- s_r_ready  in  8  per-master R ready; bits [7:master_n] ignored
- outstanding_cnt  out  5  current grant FIFO occupancy

Behaviour:
- Reset: FIFO empty, ar_grant_ready=1, m_r_ready=0, s_r_valid=0, s_r_payload=0, s_r_last=0, outstanding_cnt=0.
- Grant FIFO:
  - Push when ar_grant_valid & ar_grant_ready.
  - Pop when m_r_valid & m_r_ready & m_r_last.
  - Push and pop in the same cycle are legal when not full, and leave the count unchanged.
  - When full, ar_grant_ready=0 and pushes are ignored. An asserted ar_grant_valid while full is a protocol violation (simulation assertion).
  - Read/write pointers wrap modulo grant_fifo_depth.
  - Head entry = target of the current burst.
- Downstream accept: m_r_ready = fifo_empty_n & ~skid_full.
  - No R beat is accepted without a pending grant.
  - A grant pushed in cycle N becomes usable for an R beat in cycle N+1, not N.
- Skid buffer, two registers (main, skid), each holding {payload, last, onehot tag}:
  - An accepted beat goes to main if main is empty or is draining this cycle; otherwise it goes to skid.
  - When main drains and skid is full, skid moves to main.
  - skid_full deasserts m_r_ready the following cycle.
- Output:
  - s_r_valid[i] = main_valid & main_tag[i].
  - Main drains when main_valid & |(main_tag & s_r_ready[master_n-1:0]).
  - Readiness of non-target masters has no effect.
- Latency: 1 cycle from downstream handshake to s_r_valid. Sustained throughput is 1 beat/cycle when the target master holds ready high.
- Back-to-back bursts to different masters: the beat after a last beat is tagged with the new FIFO head, with no bubble.
- Ordering: beats are delivered strictly in acceptance order; there is no reordering across masters.
- Reset mid-burst: all buffered beats and pending grants are discarded. The upstream and downstream sides are reset together.

Decomposition:
- Shared package constants: R payload width 34, maximum master count 8, clogb2 function.
- One natural sub-module: grant_id_fifo (synchronous FIFO, width master_n, depth grant_fifo_depth, with full/empty_n/count). The skid buffer and routing stay inline.

Test Plan:
- Single burst: push grant 4'b0010, then 4 R beats with last on the 4th, all ready=1 -> s_r_valid=8'h02 on 4 consecutive cycles, each 1 cycle after its downstream beat; outstanding_cnt goes 1 to 0 after the last beat.
- R before grant: m_r_valid=1 with FIFO empty -> m_r_ready=0 and s_r_valid=0 until a grant is pushed; the beat is then routed to that master.
- Back-to-back: grants 0001 then 1000, two 2-beat bursts streamed continuously -> s_r_valid=01,01,08,08 with no idle cycle; s_r_last is high on the 2nd and 4th beats.
- Backpressure: target s_r_ready=0 for 3 cycles mid-burst -> skid fills, m_r_ready drops, no beat is lost or duplicated; the data sequence 0xA0..0xA3 arrives in order.
- Full FIFO: 4 grants pushed with no R traffic -> ar_grant_ready=0 and outstanding_cnt=4; a last beat then arrives simultaneously with an attempted push -> ready returns to 1 the next cycle and the count is 3.
- Reset while 2 beats are buffered and 2 grants are pending -> all outputs return to their reset values immediately; after release, a fresh grant and burst route correctly.

Source files
------------

// File: rtl/axi_rchn_router_pkg.sv
// Shared constants, beat record and helpers for the AXI read-data return router.
package axi_rchn_router_pkg;

   localparam int unsigned R_PAYLOAD_W = 34;
   localparam int unsigned MAX_MASTERS = 8;
   localparam int unsigned CNT_OUT_W   = 5;

   // One buffered R beat; vld is the one-hot target master, all-zero when empty.
   typedef struct packed {
      logic [R_PAYLOAD_W-1:0] payload;
      logic                   last;
      logic [MAX_MASTERS-1:0] vld;
   } r_beat_t;

   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/axi_rchn_router_grant_id_fifo.sv
// Synchronous FIFO of one-hot granted-master IDs; head is the target of the burst in flight.
module axi_rchn_router_grant_id_fifo
   import axi_rchn_router_pkg::*;
#(
   parameter  int unsigned WIDTH = 4,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = clogb2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_c_o,
   output logic             not_full_o,
   output logic             empty_n_nxt_c_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             not_full_q, not_full_d;
   logic             empty_n_q, empty_n_d;
   logic             push_ok, pop_ok;

   assign push_ok = push_i & not_full_q;
   assign pop_ok  = pop_i & empty_n_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop_ok);
      count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      not_full_d = (count_d != CNT_W'(DEPTH));
      empty_n_d  = (count_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         not_full_q <= 1'b1;
         empty_n_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         not_full_q <= not_full_d;
         empty_n_q  <= empty_n_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign head_c_o        = mem_q[rd_ptr_q];
   assign not_full_o      = not_full_q;
   assign empty_n_nxt_c_o = empty_n_d;
   assign count_o         = count_q;

endmodule

// File: rtl/axi_rchn_router.sv
// AXI R-channel return router: steers downstream R beats to the master that won
// the matching AR, through a two-entry skid buffer so all upstream outputs are registered.
module axi_rchn_router
   import axi_rchn_router_pkg::*;
#(
   parameter int unsigned master_n         = 4,
   parameter int unsigned grant_fifo_depth = 4,
   parameter int unsigned simulation_delay = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ar_grant_valid,
   input  logic [master_n-1:0]    ar_grant_onehot,
   output logic                   ar_grant_ready,
   input  logic [R_PAYLOAD_W-1:0] m_r_payload,
   input  logic                   m_r_last,
   input  logic                   m_r_valid,
   output logic                   m_r_ready,
   output logic [R_PAYLOAD_W-1:0] s_r_payload,
   output logic                   s_r_last,
   output logic [MAX_MASTERS-1:0] s_r_valid,
   input  logic [MAX_MASTERS-1:0] s_r_ready,
   output logic [CNT_OUT_W-1:0]   outstanding_cnt
);

   localparam int unsigned FIFO_CNT_W = clogb2(grant_fifo_depth) + 1;

   logic [master_n-1:0]   head_tag;
   logic                  fifo_not_full;
   logic                  fifo_empty_n_nxt;
   logic [FIFO_CNT_W-1:0] fifo_count;
   logic                  r_accept, r_pop, main_drain;
   r_beat_t               main_q, main_d;
   r_beat_t               skid_q, skid_d;
   r_beat_t               in_beat;
   logic                  m_r_ready_q, m_r_ready_d;

   assign r_accept   = m_r_valid & m_r_ready_q;
   assign r_pop      = r_accept & m_r_last;
   // vld bits above master_n are always zero, so unused ready bits cannot drain main.
   assign main_drain = |(main_q.vld & s_r_ready);

   axi_rchn_router_grant_id_fifo #(
      .WIDTH (master_n),
      .DEPTH (grant_fifo_depth)
   ) u_grant_fifo (
      .clk             (clk),
      .rst_n           (rst_n),
      .push_i          (ar_grant_valid),
      .data_i          (ar_grant_onehot),
      .pop_i           (r_pop),
      .head_c_o        (head_tag),
      .not_full_o      (fifo_not_full),
      .empty_n_nxt_c_o (fifo_empty_n_nxt),
      .count_o         (fifo_count)
   );

   // Main/skid steering; ready is computed from next-state so it can be registered.
   always_comb begin
      in_beat.payload = m_r_payload;
      in_beat.last    = m_r_last;
      in_beat.vld     = MAX_MASTERS'(head_tag);
      main_d          = main_q;
      skid_d          = skid_q;
      if (!(|main_q.vld) || main_drain) begin
         if (|skid_q.vld) begin
            main_d     = skid_q;
            skid_d.vld = '0;
         end else if (r_accept) begin
            main_d = in_beat;
         end else begin
            main_d.vld = '0;
         end
      end else if (r_accept) begin
         skid_d = in_beat;
      end
      m_r_ready_d = fifo_empty_n_nxt & ~(|skid_d.vld);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q      <= '0;
         skid_q      <= '0;
         m_r_ready_q <= 1'b0;
      end else begin
         main_q      <= main_d;
         skid_q      <= skid_d;
         m_r_ready_q <= m_r_ready_d;
      end
   end

   assign ar_grant_ready  = fifo_not_full;
   assign m_r_ready       = m_r_ready_q;
   assign s_r_payload     = main_q.payload;
   assign s_r_last        = main_q.last;
   assign s_r_valid       = main_q.vld;
   assign outstanding_cnt = CNT_OUT_W'(fifo_count);

   // A grant offered while full is dropped; a same-cycle last-beat pop makes the attempt harmless.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(ar_grant_valid && !fifo_not_full && !r_pop))
            else $error("axi_rchn_router: AR grant offered while grant FIFO full");
         assert (!ar_grant_valid || $onehot(ar_grant_onehot))
            else $error("axi_rchn_router: AR grant ID is not one-hot");
         assert (master_n >= 2 && master_n <= MAX_MASTERS &&
                 grant_fifo_depth >= 2 && grant_fifo_depth <= 16 &&
                 (grant_fifo_depth & (grant_fifo_depth - 1)) == 0 &&
                 simulation_delay <= 1000)
            else $error("axi_rchn_router: parameter out of range");
      end
   end

endmodule

// File: tb/tb_axi_rchn_router.sv
// Directed self-checking bench for axi_rchn_router (master_n=4, grant_fifo_depth=4).
module tb_axi_rchn_router;

   logic        clk;
   logic        rst_n;
   logic        ar_grant_valid;
   logic [3:0]  ar_grant_onehot;
   logic        ar_grant_ready;
   logic [33:0] m_r_payload;
   logic        m_r_last;
   logic        m_r_valid;
   logic        m_r_ready;
   logic [33:0] s_r_payload;
   logic        s_r_last;
   logic [7:0]  s_r_valid;
   logic [7:0]  s_r_ready;
   logic [4:0]  outstanding_cnt;

   int total = 0;
   int bad   = 0;

   axi_rchn_router #(
      .master_n         (4),
      .grant_fifo_depth (4),
      .simulation_delay (1)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ar_grant_valid  (ar_grant_valid),
      .ar_grant_onehot (ar_grant_onehot),
      .ar_grant_ready  (ar_grant_ready),
      .m_r_payload     (m_r_payload),
      .m_r_last        (m_r_last),
      .m_r_valid       (m_r_valid),
      .m_r_ready       (m_r_ready),
      .s_r_payload     (s_r_payload),
      .s_r_last        (s_r_last),
      .s_r_valid       (s_r_valid),
      .s_r_ready       (s_r_ready),
      .outstanding_cnt (outstanding_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
         else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         end
   endtask

   task automatic beat(input logic [33:0] pl, input logic last, input logic vld);
      m_r_payload = pl;
      m_r_last    = last;
      m_r_valid   = vld;
   endtask

   initial begin
      rst_n = 1'b0; ar_grant_valid = 1'b0; ar_grant_onehot = '0;
      beat(34'h0, 1'b0, 1'b0); s_r_ready = 8'hFF;
      cyc(); cyc();
      chk("rst_ar_ready", 64'(ar_grant_ready), 64'd1);
      chk("rst_m_ready", 64'(m_r_ready), 64'd0);
      chk("rst_s_valid", 64'(s_r_valid), 64'h00);
      chk("rst_payload", 64'(s_r_payload), 64'h0);
      chk("rst_last", 64'(s_r_last), 64'd0);
      chk("rst_cnt", 64'(outstanding_cnt), 64'd0);
      rst_n = 1'b1;
      cyc();

      // single 4-beat burst to master 1
      ar_grant_valid = 1'b1; ar_grant_onehot = 4'b0010;
      cyc();
      ar_grant_valid = 1'b0;
      chk("t1_cnt_push", 64'(outstanding_cnt), 64'd1);
      chk("t1_m_ready", 64'(m_r_ready), 64'd1);
      beat(34'h10, 1'b0, 1'b1); cyc();
      chk("t1_b0_valid", 64'(s_r_valid), 64'h02);
      chk("t1_b0_data", 64'(s_r_payload), 64'h10);
      beat(34'h11, 1'b0, 1'b1); cyc();
      chk("t1_b1_data", 64'(s_r_payload), 64'h11);
      beat(34'h12, 1'b0, 1'b1); cyc();
      chk("t1_b2_valid", 64'(s_r_valid), 64'h02);
      chk("t1_b2_cnt", 64'(outstanding_cnt), 64'd1);
      beat(34'h13, 1'b1, 1'b1); cyc();
      chk("t1_b3_valid", 64'(s_r_valid), 64'h02);
      chk("t1_b3_data", 64'(s_r_payload), 64'h13);
      chk("t1_b3_last", 64'(s_r_last), 64'd1);
      chk("t1_cnt_pop", 64'(outstanding_cnt), 64'd0);
      chk("t1_m_ready_off", 64'(m_r_ready), 64'd0);
      beat(34'h0, 1'b0, 1'b0); cyc();
      chk("t1_idle", 64'(s_r_valid), 64'h00);

      // R beat waiting before its grant exists
      beat(34'h20, 1'b1, 1'b1); cyc();
      chk("t2_no_ready", 64'(m_r_ready), 64'd0);
      chk("t2_no_valid", 64'(s_r_valid), 64'h00);
      cyc();
      chk("t2_still_idle", 64'(s_r_valid), 64'h00);
      ar_grant_valid = 1'b1; ar_grant_onehot = 4'b0100;
      cyc();
      ar_grant_valid = 1'b0;
      chk("t2_grant_valid", 64'(s_r_valid), 64'h00);
      chk("t2_ready_up", 64'(m_r_ready), 64'd1);
      cyc();
      chk("t2_routed", 64'(s_r_valid), 64'h04);
      chk("t2_data", 64'(s_r_payload), 64'h20);
      chk("t2_cnt", 64'(outstanding_cnt), 64'd0);
      beat(34'h0, 1'b0, 1'b0); cyc();

      // back-to-back bursts to masters 0 and 3
      ar_grant_valid = 1'b1; ar_grant_onehot = 4'b0001; cyc();
      ar_grant_onehot = 4'b1000; cyc();
      ar_grant_valid = 1'b0;
      chk("t3_cnt2", 64'(outstanding_cnt), 64'd2);
      beat(34'h30, 1'b0, 1'b1); cyc();
      chk("t3_b0", 64'(s_r_valid), 64'h01);
      beat(34'h31, 1'b1, 1'b1); cyc();
      chk("t3_b1", 64'(s_r_valid), 64'h01);
      chk("t3_b1_last", 64'(s_r_last), 64'd1);
      chk("t3_b1_cnt", 64'(outstanding_cnt), 64'd1);
      beat(34'h32, 1'b0, 1'b1); cyc();
      chk("t3_b2", 64'(s_r_valid), 64'h08);
      chk("t3_b2_last", 64'(s_r_last), 64'd0);
      chk("t3_b2_data", 64'(s_r_payload), 64'h32);
      beat(34'h33, 1'b1, 1'b1); cyc();
      chk("t3_b3", 64'(s_r_valid), 64'h08);
      chk("t3_b3_last", 64'(s_r_last), 64'd1);
      chk("t3_cnt0", 64'(outstanding_cnt), 64'd0);
      beat(34'h0, 1'b0, 1'b0); cyc();

      // backpressure from master 1 only; other masters' ready stays high
      ar_grant_valid = 1'b1; ar_grant_onehot = 4'b0010; cyc();
      ar_grant_valid = 1'b0;
      beat(34'hA0, 1'b0, 1'b1); cyc();
      chk("t4_a0", 64'(s_r_payload), 64'hA0);
      chk("t4_ready_c1", 64'(m_r_ready), 64'd1);
      beat(34'hA1, 1'b0, 1'b1); s_r_ready = 8'hFD; cyc();
      chk("t4_hold_a0", 64'(s_r_payload), 64'hA0);
      chk("t4_skid_full", 64'(m_r_ready), 64'd0);
      beat(34'hA2, 1'b0, 1'b1); cyc();
      chk("t4_hold_c3", 64'(s_r_payload), 64'hA0);
      chk("t4_valid_c3", 64'(s_r_valid), 64'h02);
      cyc();
      chk("t4_hold_c4", 64'(s_r_payload), 64'hA0);
      chk("t4_ready_c4", 64'(m_r_ready), 64'd0);
      s_r_ready = 8'hFF; cyc();
      chk("t4_a1", 64'(s_r_payload), 64'hA1);
      chk("t4_ready_back", 64'(m_r_ready), 64'd1);
      cyc();
      chk("t4_a2", 64'(s_r_payload), 64'hA2);
      beat(34'hA3, 1'b1, 1'b1); cyc();
      chk("t4_a3", 64'(s_r_payload), 64'hA3);
      chk("t4_a3_last", 64'(s_r_last), 64'd1);
      chk("t4_cnt", 64'(outstanding_cnt), 64'd0);
      beat(34'h0, 1'b0, 1'b0); cyc();
      chk("t4_drained", 64'(s_r_valid), 64'h00);

      // fill the grant FIFO, then pop with a simultaneous push attempt
      ar_grant_valid = 1'b1;
      ar_grant_onehot = 4'b0001; cyc();
      ar_grant_onehot = 4'b0010; cyc();
      ar_grant_onehot = 4'b0100; cyc();
      ar_grant_onehot = 4'b1000; cyc();
      ar_grant_valid = 1'b0;
      chk("t5_full_ready", 64'(ar_grant_ready), 64'd0);
      chk("t5_full_cnt", 64'(outstanding_cnt), 64'd4);
      ar_grant_valid = 1'b1; ar_grant_onehot = 4'b0001;
      beat(34'h50, 1'b1, 1'b1); cyc();
      ar_grant_valid = 1'b0;
      chk("t5_ready_back", 64'(ar_grant_ready), 64'd1);
      chk("t5_cnt3", 64'(outstanding_cnt), 64'd3);
      chk("t5_route", 64'(s_r_valid), 64'h01);

      // buffer two beats with two grants still pending, then reset
      s_r_ready = 8'h00;
      beat(34'h60, 1'b1, 1'b1); cyc();
      beat(34'h0, 1'b0, 1'b0);
      chk("t6_cnt2", 64'(outstanding_cnt), 64'd2);
      chk("t6_blocked", 64'(m_r_ready), 64'd0);
      chk("t6_main", 64'(s_r_payload), 64'h50);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(s_r_valid), 64'h00);
      chk("t6_rst_payload", 64'(s_r_payload), 64'h0);
      chk("t6_rst_last", 64'(s_r_last), 64'd0);
      chk("t6_rst_m_ready", 64'(m_r_ready), 64'd0);
      chk("t6_rst_ar_ready", 64'(ar_grant_ready), 64'd1);
      chk("t6_rst_cnt", 64'(outstanding_cnt), 64'd0);
      cyc();
      rst_n = 1'b1; s_r_ready = 8'hFF;
      cyc();
      chk("t6_post_idle", 64'(s_r_valid), 64'h00);
      ar_grant_valid = 1'b1; ar_grant_onehot = 4'b1000; cyc();
      ar_grant_valid = 1'b0;
      chk("t6_fresh_cnt", 64'(outstanding_cnt), 64'd1);
      beat(34'h70, 1'b1, 1'b1); cyc();
      chk("t6_fresh_valid", 64'(s_r_valid), 64'h08);
      chk("t6_fresh_data", 64'(s_r_payload), 64'h70);
      chk("t6_fresh_cnt0", 64'(outstanding_cnt), 64'd0);
      beat(34'h0, 1'b0, 1'b0); cyc();
      chk("t6_end_idle", 64'(s_r_valid), 64'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
